// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port RAM.
// Port 0 is the CPU, port 1 is DMA/debug. One transaction at a time:
// IDLE -> ACCESS -> (WAIT for reads) -> DONE -> IDLE.
//
// Handshake: rN_req is a level. It is sampled only in IDLE; on grant, the
// port's we/addr/wdata are latched and later changes to them are ignored.
// rN_ack is a single-cycle pulse in DONE. For reads, rN_rdata is valid at
// the ack and holds until that port's next completed read.
module ram_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        r0_req,
  input  logic        r0_we,
  input  logic [7:0]  r0_addr,
  input  logic [15:0] r0_wdata,
  output logic        r0_ack,
  output logic [15:0] r0_rdata,
  input  logic        r1_req,
  input  logic        r1_we,
  input  logic [7:0]  r1_addr,
  input  logic [15:0] r1_wdata,
  output logic        r1_ack,
  output logic [15:0] r1_rdata,
  output logic        ram_read,
  output logic        ram_write,
  output logic [7:0]  ram_addr,
  output logic [15:0] ram_data_in,
  input  logic [15:0] ram_data_out,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  state_t      state;
  state_t      state_next;
  logic        last_grant;   // port served most recently; 1 after reset so port 0 wins the first tie
  logic        grant;        // winner if a grant happens this cycle
  logic        lat_port;     // port owning the current transaction
  logic        lat_we;       // direction of the current transaction
  logic        sel_we;
  logic [7:0]  sel_addr;
  logic [15:0] sel_wdata;
  logic        any_req;

  assign any_req = r0_req | r1_req;

  // Round-robin pick and mux of the winner's request fields
  always_comb begin
    grant = 1'b0;
    if (r0_req && r1_req) begin
      grant = ~last_grant;
    end else if (r1_req) begin
      grant = 1'b1;
    end
    sel_we    = grant ? r1_we    : r0_we;
    sel_addr  = grant ? r1_addr  : r0_addr;
    sel_wdata = grant ? r1_wdata : r0_wdata;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = ACCESS;
      ACCESS:  state_next = lat_we ? DONE : WAIT;
      WAIT:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes, acks and busy decoded from state; forced low while reset is held
  always_comb begin
    ram_read  = 1'b0;
    ram_write = 1'b0;
    r0_ack    = 1'b0;
    r1_ack    = 1'b0;
    busy      = 1'b0;
    if (!reset) begin
      busy      = (state != IDLE);
      ram_write = (state == ACCESS) &&  lat_we;
      ram_read  = (state == ACCESS) && !lat_we;
      r0_ack    = (state == DONE)   && !lat_port;
      r1_ack    = (state == DONE)   &&  lat_port;
    end
  end

  // State register, request latch, RAM address/data and read-data capture.
  // ram_addr/ram_data_in double as the latched request fields, so they
  // naturally hold their last driven values outside ACCESS.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      lat_port    <= 1'b0;
      lat_we      <= 1'b0;
      ram_addr    <= 8'h00;
      ram_data_in <= 16'h0000;
      r0_rdata    <= 16'h0000;
      r1_rdata    <= 16'h0000;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (any_req) begin
            lat_port <= grant;
            lat_we   <= sel_we;
            ram_addr <= sel_addr;
            if (sel_we) ram_data_in <= sel_wdata;
          end
        end
        WAIT: begin
          if (lat_port) r1_rdata <= ram_data_out;
          else          r0_rdata <= ram_data_out;
        end
        DONE: last_grant <= lat_port;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural RAM, reference memory, expected-ack
// queue checked by a monitor, table-driven single transactions plus
// hand-written multi-cycle sequences.
module tb_ram_arbiter;

  logic        clk;
  logic        reset;
  logic        r0_req, r0_we, r1_req, r1_we;
  logic [7:0]  r0_addr, r1_addr;
  logic [15:0] r0_wdata, r1_wdata;
  logic        r0_ack, r1_ack;
  logic [15:0] r0_rdata, r1_rdata;
  logic        ram_read, ram_write;
  logic [7:0]  ram_addr;
  logic [15:0] ram_data_in;
  logic [15:0] ram_data_out;
  logic        busy;

  int errors = 0;
  int checks = 0;

  // {we, port, rdata-if-read}
  logic [17:0] exp_q[$];
  logic [15:0] ref_mem[256];
  logic [15:0] mem[256];
  logic [15:0] rd_model[2];
  logic [17:0] mon_e;
  logic        mon_p;

  typedef struct {
    logic        p;
    logic        we;
    logic [7:0]  a;
    logic [15:0] d;
    int          lat;
  } vec_t;
  vec_t vecs[8];

  ram_arbiter dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ack(r0_ack), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ack(r1_ack), .r1_rdata(r1_rdata),
    .ram_read(ram_read), .ram_write(ram_write), .ram_addr(ram_addr),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out), .busy(busy)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "time limit");
  end

  function automatic logic [15:0] init_val(input int i);
    return 16'(i * 327 + 11325);
  endfunction

  // Behavioural RAM: read data appears the cycle after ram_read
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    end else begin
      if (ram_write) mem[ram_addr] <= ram_data_in;
      if (ram_read)  ram_data_out  <= mem[ram_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: per-cycle invariants and ack scoreboard
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      rd_model[0] = 16'h0;
      rd_model[1] = 16'h0;
    end else begin
      chk("one_strobe", 32'(ram_read & ram_write), 32'(0));
      chk("one_ack", 32'(r0_ack & r1_ack), 32'(0));
      if (r0_ack || r1_ack) begin
        if (exp_q.size() == 0) begin
          chk("spurious_ack", 32'({r0_ack, r1_ack}), 32'(0));
        end else begin
          mon_e = exp_q.pop_front();
          mon_p = r1_ack;
          chk("ack_port", 32'(mon_p), 32'(mon_e[16]));
          if (!mon_e[17]) rd_model[mon_p] = mon_e[15:0];
          chk("r0_rdata", 32'(r0_rdata), 32'(rd_model[0]));
          chk("r1_rdata", 32'(r1_rdata), 32'(rd_model[1]));
        end
      end
    end
  end

  task automatic reinit_ref();
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_acks"}, 32'({r0_ack, r1_ack}), 32'(0));
    chk({tag, "_strobes"}, 32'({ram_read, ram_write}), 32'(0));
    chk({tag, "_ram_addr"}, 32'(ram_addr), 32'(0));
    chk({tag, "_ram_data_in"}, 32'(ram_data_in), 32'(0));
    chk({tag, "_rdata"}, 32'({r0_rdata, r1_rdata}), 32'(0));
  endtask

  // Hold reset for two edges, check reset values, release, leave one idle cycle
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    reinit_ref();
    reset = 1'b0;
    @(negedge clk);
  endtask

  // One transaction from a single port; called at a negedge with the DUT idle.
  // req is dropped right after it is sampled and the fields are scrambled,
  // so the transaction must run from the latched copy.
  task automatic do_txn(input logic p, input logic we, input logic [7:0] a,
                        input logic [15:0] d, input int exp_lat);
    int lat;
    chk("idle_before", 32'(busy), 32'(0));
    exp_q.push_back({we, p, we ? d : ref_mem[a]});
    if (we) ref_mem[a] = d;
    if (!p) begin
      r0_req = 1'b1; r0_we = we; r0_addr = a; r0_wdata = d;
    end else begin
      r1_req = 1'b1; r1_we = we; r1_addr = a; r1_wdata = d;
    end
    @(posedge clk);
    #1;
    r0_req = 1'b0; r1_req = 1'b0;
    r0_we = 1'($urandom); r0_addr = 8'($urandom); r0_wdata = 16'($urandom);
    r1_we = 1'($urandom); r1_addr = 8'($urandom); r1_wdata = 16'($urandom);
    lat = 0;
    for (int i = 1; i <= 6 && lat == 0; i++) begin
      @(negedge clk);
      if (i == 1) begin
        chk("access_write", 32'(ram_write), 32'(we));
        chk("access_read", 32'(ram_read), 32'(!we));
        chk("access_addr", 32'(ram_addr), 32'(a));
        if (we) chk("access_wdata", 32'(ram_data_in), 32'(d));
      end
      if (p ? r1_ack : r0_ack) lat = i;
    end
    chk("ack_latency", 32'(lat), 32'(exp_lat));
    @(negedge clk);
  endtask

  initial begin
    int acks;
    int last;
    int first_port;
    logic p, we;
    logic [7:0] a;
    logic [15:0] d;

    reset = 1'b1;
    r0_req = 1'b0; r0_we = 1'b0; r0_addr = 8'h0; r0_wdata = 16'h0;
    r1_req = 1'b0; r1_we = 1'b0; r1_addr = 8'h0; r1_wdata = 16'h0;

    vecs[0] = '{1'b0, 1'b1, 8'h12, 16'hBEEF, 2};
    vecs[1] = '{1'b1, 1'b0, 8'h12, 16'h0000, 3};
    vecs[2] = '{1'b0, 1'b0, 8'h12, 16'h0000, 3};
    vecs[3] = '{1'b1, 1'b1, 8'hFF, 16'h1234, 2};
    vecs[4] = '{1'b0, 1'b0, 8'hFF, 16'h0000, 3};
    vecs[5] = '{1'b1, 1'b0, 8'h00, 16'h0000, 3};
    vecs[6] = '{1'b0, 1'b1, 8'h00, 16'h0000, 2};
    vecs[7] = '{1'b1, 1'b0, 8'h00, 16'h0000, 3};

    do_reset();

    // Tie right after reset: both ports read, order 0,1,0,1
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back({1'b0, 1'b0, ref_mem[8'h20]});
      exp_q.push_back({1'b0, 1'b1, ref_mem[8'h21]});
    end
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 8'h20;
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 8'h21;
    acks = 0;
    for (int i = 0; i < 40 && acks < 4; i++) begin
      @(negedge clk);
      if (r0_ack || r1_ack) begin
        acks++;
        if (acks == 4) begin r0_req = 1'b0; r1_req = 1'b0; end
      end
    end
    chk("tie_acks", 32'(acks), 32'(4));
    @(negedge clk);

    // Table of single transactions
    for (int i = 0; i < 8; i++) begin
      do_txn(vecs[i].p, vecs[i].we, vecs[i].a, vecs[i].d, vecs[i].lat);
    end

    // Random single transactions over a small address window
    for (int i = 0; i < 12; i++) begin
      p  = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      a  = 8'($urandom_range(0, 15));
      d  = 16'($urandom);
      do_txn(p, we, a, d, we ? 2 : 3);
    end

    // Held port-0 write request: back-to-back writes, acks 3 cycles apart
    for (int k = 0; k < 3; k++) exp_q.push_back({1'b1, 1'b0, 16'hA5A5});
    ref_mem[8'h30] = 16'hA5A5;
    r0_req = 1'b1; r0_we = 1'b1; r0_addr = 8'h30; r0_wdata = 16'hA5A5;
    acks = 0;
    last = -1;
    for (int i = 0; i < 40 && acks < 3; i++) begin
      @(negedge clk);
      if (r0_ack) begin
        if (last >= 0) chk("held_ack_spacing", 32'(i - last), 32'(3));
        last = i;
        acks++;
        if (acks == 3) r0_req = 1'b0;
      end
    end
    chk("held_acks", 32'(acks), 32'(3));
    @(negedge clk);
    do_txn(1'b1, 1'b0, 8'h30, 16'h0000, 3);

    // Make port 0 the last grant so that, without reset, port 1 would win the next tie
    do_txn(1'b0, 1'b0, 8'h31, 16'h0000, 3);

    // Reset during the ACCESS cycle of a port-0 write
    exp_q.push_back({1'b1, 1'b0, 16'h1111});
    r0_req = 1'b1; r0_we = 1'b1; r0_addr = 8'h40; r0_wdata = 16'h1111;
    @(posedge clk);
    #1;
    reset = 1'b1;
    r0_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("midop");
    reinit_ref();
    reset = 1'b0;
    @(negedge clk);

    // After the abort, port 0 wins the tie and the aborted write did not land
    exp_q.push_back({1'b0, 1'b0, ref_mem[8'h40]});
    exp_q.push_back({1'b0, 1'b1, ref_mem[8'h41]});
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 8'h40;
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 8'h41;
    acks = 0;
    first_port = -1;
    for (int i = 0; i < 40 && acks < 2; i++) begin
      @(negedge clk);
      if (r0_ack || r1_ack) begin
        acks++;
        if (first_port < 0) first_port = r1_ack ? 1 : 0;
        if (r0_ack) r0_req = 1'b0;
        if (r1_ack) r1_req = 1'b0;
      end
    end
    chk("post_reset_acks", 32'(acks), 32'(2));
    chk("post_reset_first", 32'(first_port), 32'(0));
    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Ports SHALL be, clock and reset first:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- r0_req  in  1  port 0 (CPU) access request, level
- r0_we  in  1  port 0: 1 = write, 0 = read
- r0_addr  in  8  port 0 RAM address
- r0_wdata  in  16  port 0 write data
- r0_ack  out  1  port 0 completion pulse
- r0_rdata  out  16  port 0 read data
- r1_req, r1_we, r1_addr, r1_wdata, r1_ack, r1_rdata  same as port 0, for port 1 (DMA/debug)
- ram_read  out  1  RAM read strobe
- ram_write  out  1  RAM write strobe
- ram_addr  out  8  RAM address
- ram_data_in  out  16  data written into RAM
- ram_data_out  in  16  data from RAM; valid the cycle after ram_read
- busy  out  1  high whenever state is not IDLE
REQ-002 The block SHALL use one clock; reset SHALL be synchronous and active-high.

Function
REQ-003 FSM states SHALL be IDLE, ACCESS, WAIT, DONE.
REQ-004 IDLE: with no request, stay in IDLE; with any request, select a winner, latch its we/addr/wdata and port id, then go to ACCESS.
REQ-005 Arbitration SHALL be round-robin on last_grant: with one request, grant it; with both, grant the port other than last_grant.
REQ-006 ACCESS SHALL last exactly one cycle and drive the latched ram_addr; it asserts ram_write with ram_data_in = latched wdata if we=1, else ram_read.
REQ-007 After ACCESS, a write SHALL go to DONE and a read SHALL go to WAIT.
REQ-008 WAIT: capture ram_data_out into the winner's rNN_rdata, then go to DONE.
REQ-009 DONE: pulse the winner's ack high for exactly one cycle, set last_grant to the winner, then go to IDLE.
REQ-010 Latency from req sampled in IDLE at edge N: write ack SHALL be high in cycle N+2; read ack in cycle N+3, with rdata valid at the ack.
REQ-011 ram_read and ram_write SHALL never be high together, and SHALL be high only in ACCESS.
REQ-012 Outside ACCESS, ram_addr and ram_data_in SHALL hold their last driven values.
REQ-013 rNN_rdata SHALL hold until the next completed read for that port; a write SHALL not change it.
REQ-014 Requester inputs SHALL be sampled only in IDLE; changes to them during a transaction SHALL be ignored.
REQ-015 A req dropped mid-transaction SHALL still complete the transaction and pulse the ack.
REQ-016 A req still high in the IDLE cycle after the ack SHALL count as a new request.
REQ-017 Only one ack SHALL be high in any cycle, and only in DONE.
REQ-018 A new request SHALL be accepted at most every 3 cycles (write) or 4 cycles (read); there are no back-to-back grants without IDLE.

Reset
REQ-019 While reset is high: state = IDLE; last_grant = 1 (port 0 wins the first tie); ram_read = ram_write = 0; ram_addr = 0; ram_data_in = 0; r0_ack = r1_ack = 0; r0_rdata = r1_rdata = 0; busy = 0.
REQ-020 Reset asserted mid-transaction SHALL abort it: no strobe and no ack in the following cycle, and the aborted requester gets no ack.

Verification
REQ-021 Single write: r0_req=1, we=1, addr=0x12, wdata=0xBEEF at edge 0 -> ram_write=1, ram_addr=0x12, ram_data_in=0xBEEF in cycle 1; r0_ack=1 in cycle 2.
REQ-022 Single read: r1_req, we=0, addr=0x12, RAM returns 0xBEEF -> ram_read=1 in cycle 1; r1_ack=1 and r1_rdata=0xBEEF in cycle 3; r0_rdata unchanged.
REQ-023 Tie after reset: both req held high with reads -> grant order 0,1,0,1, each ack one cycle, never both acks in one cycle.
REQ-024 Request drop: r0 read, r0_req low in cycle 1 -> read still issued, r0_ack pulses in cycle 3.
REQ-025 Reset mid-op: reset asserted in the ACCESS cycle of a write -> next cycle IDLE, busy=0, no r0_ack; after release, r0 wins the tie with r1.
REQ-026 Held req: r0_req held high, no r1 -> back-to-back write transactions, with acks every 3 cycles.
